sevenseg_scan_driver: RTL and testbench

- Time-multiplexing scanner placed directly upstream of sevenseg_data_driver.
- Holds a multi-digit BCD/hex value and steps through the digits one at a time.
- Presents the current digit's 4-bit code on digit_data, which feeds the decoder's data input, and drives the matching common-anode/cathode enable.
- Adds per-digit ghosting guard, optional leading-zero blanking and tear-free frame-synchronous value update.

---
 rtl/sevenseg_pkg.sv | 12 +
 rtl/sevenseg_scan_timer.sv | 37 +++
 rtl/sevenseg_scan_driver.sv | 97 +++++++++
 tb/tb_sevenseg_scan_driver.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared constants and helpers for the seven-segment scan driver
package sevenseg_pkg;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int MAX_DIGITS = 8;
  typedef enum logic {PH_GUARD, PH_DRIVE} phase_e;
  function automatic logic [3:0] digit_nibble(input logic [4*MAX_DIGITS-1:0] vec, input logic [2:0] idx);
    return vec[{idx, 2'b00} +: 4];
  endfunction
  function automatic logic en_level(input logic asserted, input logic active_low);
    return asserted ^ active_low;
  endfunction
endpackage

// File: rtl/sevenseg_scan_timer.sv
// sevenseg_scan_timer: slot/digit counters, frame wrap and guard-phase flag
//   clk, rst      : clock, async active-high reset
//   o_digit_idx   : digit currently being scanned
//   o_wrap_frame  : last cycle of the last digit slot
//   o_guard       : slot is still in its all-off guard window
module sevenseg_scan_timer #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 500,
  parameter int SW          = 16,
  parameter int DW          = 2
) (
  input  logic          clk,
  input  logic          rst,
  output logic [DW-1:0] o_digit_idx,
  output logic          o_wrap_frame,
  output logic          o_guard
);
  logic [SW-1:0] r_slot_cnt;
  logic [DW-1:0] r_digit_idx;
  logic          w_slot_wrap;
  logic          w_last_digit;
  assign w_slot_wrap  = r_slot_cnt == SW'(REFRESH_DIV - 1);
  assign w_last_digit = r_digit_idx == DW'(NUM_DIGITS - 1);
  assign o_wrap_frame = w_slot_wrap && w_last_digit;
  assign o_guard      = (GUARD > 0) && (r_slot_cnt < SW'(GUARD));
  assign o_digit_idx  = r_digit_idx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
    end else begin
      r_slot_cnt <= w_slot_wrap ? '0 : r_slot_cnt + SW'(1);
      if (w_slot_wrap) r_digit_idx <= w_last_digit ? '0 : r_digit_idx + DW'(1);
    end
  end
endmodule

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: time-multiplexed digit scanner feeding sevenseg_data_driver
//   clk, rst       : clock, async active-high reset
//   i_value        : digit codes, nibble i = digit i (digit 0 rightmost)
//   i_load         : strobe capturing i_value for the next frame
//   i_blank_lz     : suppress leading zeros
//   o_digit_data   : code for the current digit (BLANK_CODE when off)
//   o_digit_en     : one-hot digit enables in asserted polarity
//   o_frame_start  : pulse on the first output cycle of digit 0
//   o_pending      : captured value waiting for the frame boundary
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int GUARD         = 500,
  parameter int EN_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_load,
  input  logic                    i_blank_lz,
  output logic [3:0]              o_digit_data,
  output logic [NUM_DIGITS-1:0]   o_digit_en,
  output logic                    o_frame_start,
  output logic                    o_pending
);
  localparam int SW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic ACT_LOW = EN_ACTIVE_LOW != 0;
  localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{ACT_LOW}};
  logic [DW-1:0]         w_digit_idx;
  logic                  w_wrap_frame;
  logic                  w_guard;
  phase_e                w_phase;
  logic [NUM_DIGITS:0]   w_zero_above;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [NUM_DIGITS-1:0] w_en_nxt;
  logic                  w_blank;
  logic [3:0]            w_data_nxt;
  logic [VW-1:0]         r_frame;
  logic [VW-1:0]         r_pend;
  logic                  r_pending;
  logic                  r_wrap_d;
  logic                  r_frame_start;
  logic [3:0]            r_digit_data;
  logic [NUM_DIGITS-1:0] r_digit_en;
  sevenseg_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .GUARD      (GUARD),
    .SW         (SW),
    .DW         (DW)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .o_digit_idx (w_digit_idx),
    .o_wrap_frame(w_wrap_frame),
    .o_guard     (w_guard)
  );
  assign w_phase = w_guard ? PH_GUARD : PH_DRIVE;
  // w_zero_above[i]: nibbles i..NUM_DIGITS-1 of the shown frame are all zero
  assign w_zero_above[NUM_DIGITS] = 1'b1;
  assign w_onehot = NUM_DIGITS'(1) << w_digit_idx;
  assign w_blank  = i_blank_lz && (w_digit_idx != '0) && w_zero_above[w_digit_idx];
  assign w_data_nxt = w_blank ? BLANK_CODE : digit_nibble(32'(r_frame), 3'(w_digit_idx));
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign w_zero_above[g] = w_zero_above[g+1] && (r_frame[4*g +: 4] == 4'h0);
    assign w_en_nxt[g] = en_level(w_onehot[g] && (w_phase == PH_DRIVE) && !w_blank, ACT_LOW);
  end
  // frame_start lags wrap by two cycles so it lines up with the registered
  // outputs of slot 0 / digit 0 rather than with the counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame       <= '0;
      r_pend        <= '0;
      r_pending     <= 1'b0;
      r_wrap_d      <= 1'b0;
      r_frame_start <= 1'b0;
      r_digit_data  <= BLANK_CODE;
      r_digit_en    <= EN_OFF;
    end else begin
      r_wrap_d      <= w_wrap_frame;
      r_frame_start <= r_wrap_d;
      r_digit_data  <= w_data_nxt;
      r_digit_en    <= w_en_nxt;
      if (i_load) r_pend <= i_value;
      if (w_wrap_frame) r_frame <= i_load ? i_value : r_pending ? r_pend : r_frame;
      r_pending <= !w_wrap_frame && (i_load || r_pending);
    end
  end
  assign o_digit_data  = r_digit_data;
  assign o_digit_en    = r_digit_en;
  assign o_frame_start = r_frame_start;
  assign o_pending     = r_pending;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb_sevenseg_scan_driver: scoreboard bench for the scan driver (4 digits, 8-cycle slots, guard 2)
module tb_sevenseg_scan_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_value = '0;
  logic        i_load = 1'b0;
  logic        i_blank_lz = 1'b0;
  logic [3:0]  o_digit_data;
  logic [3:0]  o_digit_en;
  logic        o_frame_start;
  logic        o_pending;
  typedef struct packed {logic [3:0] d; logic [3:0] e;} exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  sevenseg_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD(2), .EN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .i_value(i_value), .i_load(i_load), .i_blank_lz(i_blank_lz),
    .o_digit_data(o_digit_data), .o_digit_en(o_digit_en),
    .o_frame_start(o_frame_start), .o_pending(o_pending)
  );
  always #5 clk = ~clk;
  // expected outputs for one whole frame, one entry per cycle starting at frame_start
  task automatic push_frame(input logic [15:0] v, input logic b);
    for (int j = 0; j < 32; j++) begin
      int d = j / 8;
      int s = j % 8;
      logic bl;
      exp_t x;
      bl = b && d != 0 && (v >> (4 * d)) == 16'h0;
      x.d = bl ? 4'hF : v[4*d +: 4];
      x.e = (s < 2 || bl) ? 4'hF : ~(4'b0001 << d);
      sb.push_back(x);
    end
  endtask
  task automatic wait_fs();
    int n = 0;
    while (o_frame_start !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL wait_fs: frame_start not seen within 40 cycles");
    end
  endtask
  task automatic test_reset();
    int n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_digit_data !== 4'hF) begin errors++; $display("FAIL reset_data got=%h want=F", o_digit_data); end
    checks++;
    if (o_digit_en !== 4'hF) begin errors++; $display("FAIL reset_en got=%b want=1111", o_digit_en); end
    checks++;
    if (o_frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b want=0", o_frame_start); end
    checks++;
    if (o_pending !== 1'b0) begin errors++; $display("FAIL reset_pend got=%b want=0", o_pending); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_digit_data !== 4'h0 || o_digit_en !== 4'hF) begin
      errors++; $display("FAIL first_guard data=%h en=%b want data=0 en=1111", o_digit_data, o_digit_en);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (o_digit_en !== 4'hE) begin errors++; $display("FAIL first_drive en=%b want=1110", o_digit_en); end
    while (o_frame_start !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 30) begin errors++; $display("FAIL first_fs at cycle=%0d want=33", n + 3); end
  endtask
  task automatic test_idle();
    wait_fs();
    push_frame(16'h0000, 1'b0);
    for (int j = 0; j < 32; j++) begin
      exp_t x = sb.pop_front();
      checks++;
      if (o_digit_data !== x.d || o_digit_en !== x.e || o_frame_start !== (j == 0) || o_pending !== 1'b0) begin
        errors++;
        $display("FAIL idle j=%0d data=%h en=%b fs=%b pend=%b want data=%h en=%b fs=%b pend=0",
                 j, o_digit_data, o_digit_en, o_frame_start, o_pending, x.d, x.e, j == 0);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_load_midframe();
    wait_fs();
    push_frame(16'h0000, 1'b0);
    for (int j = 0; j < 64; j++) begin
      exp_t x = sb.pop_front();
      logic ep = j >= 6 && j <= 30;
      checks++;
      if (o_digit_data !== x.d || o_digit_en !== x.e || o_frame_start !== (j % 32 == 0) || o_pending !== ep) begin
        errors++;
        $display("FAIL load_mid j=%0d data=%h en=%b fs=%b pend=%b want data=%h en=%b fs=%b pend=%b",
                 j, o_digit_data, o_digit_en, o_frame_start, o_pending, x.d, x.e, j % 32 == 0, ep);
      end
      if (j == 5) begin i_value = 16'h1234; i_load = 1'b1; push_frame(16'h1234, 1'b0); end
      if (j == 6) i_load = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic test_blank();
    wait_fs();
    push_frame(16'h1234, 1'b1);
    for (int j = 0; j < 96; j++) begin
      exp_t x = sb.pop_front();
      logic ep = (j >= 6 && j <= 30) || (j >= 38 && j <= 62);
      checks++;
      if (o_digit_data !== x.d || o_digit_en !== x.e || o_frame_start !== (j % 32 == 0) || o_pending !== ep) begin
        errors++;
        $display("FAIL blank j=%0d data=%h en=%b fs=%b pend=%b want data=%h en=%b fs=%b pend=%b",
                 j, o_digit_data, o_digit_en, o_frame_start, o_pending, x.d, x.e, j % 32 == 0, ep);
      end
      if (j == 0) i_blank_lz = 1'b1;
      if (j == 5) begin i_value = 16'h0050; i_load = 1'b1; push_frame(16'h0050, 1'b1); end
      if (j == 37) begin i_value = 16'h0000; i_load = 1'b1; push_frame(16'h0000, 1'b1); end
      if (j == 6 || j == 38) i_load = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic test_last_wins();
    wait_fs();
    push_frame(16'h0000, 1'b0);
    for (int j = 0; j < 64; j++) begin
      exp_t x = sb.pop_front();
      logic ep = j >= 4 && j <= 30;
      checks++;
      if (o_digit_data !== x.d || o_digit_en !== x.e || o_frame_start !== (j % 32 == 0) || o_pending !== ep) begin
        errors++;
        $display("FAIL last_wins j=%0d data=%h en=%b fs=%b pend=%b want data=%h en=%b fs=%b pend=%b",
                 j, o_digit_data, o_digit_en, o_frame_start, o_pending, x.d, x.e, j % 32 == 0, ep);
      end
      if (j == 0) i_blank_lz = 1'b0;
      if (j == 3) begin i_value = 16'hAAAA; i_load = 1'b1; end
      if (j == 10) begin i_value = 16'h5555; i_load = 1'b1; push_frame(16'h5555, 1'b0); end
      if (j == 4 || j == 11) i_load = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic test_wrap_load();
    wait_fs();
    push_frame(16'h5555, 1'b0);
    for (int j = 0; j < 64; j++) begin
      exp_t x = sb.pop_front();
      checks++;
      if (o_digit_data !== x.d || o_digit_en !== x.e || o_frame_start !== (j % 32 == 0) || o_pending !== 1'b0) begin
        errors++;
        $display("FAIL wrap_load j=%0d data=%h en=%b fs=%b pend=%b want data=%h en=%b fs=%b pend=0",
                 j, o_digit_data, o_digit_en, o_frame_start, o_pending, x.d, x.e, j % 32 == 0);
      end
      if (j == 30) begin i_value = 16'h9876; i_load = 1'b1; push_frame(16'h9876, 1'b0); end
      if (j == 31) i_load = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic test_async_reset();
    wait_fs();
    push_frame(16'h9876, 1'b0);
    for (int j = 0; j < 14; j++) begin
      exp_t x = sb.pop_front();
      logic ep = j >= 3;
      checks++;
      if (o_digit_data !== x.d || o_digit_en !== x.e || o_pending !== ep) begin
        errors++;
        $display("FAIL pre_reset j=%0d data=%h en=%b pend=%b want data=%h en=%b pend=%b",
                 j, o_digit_data, o_digit_en, o_pending, x.d, x.e, ep);
      end
      if (j == 2) begin i_value = 16'h4321; i_load = 1'b1; end
      if (j == 3) i_load = 1'b0;
      if (j < 13) @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (o_digit_data !== 4'hF || o_digit_en !== 4'hF || o_frame_start !== 1'b0 || o_pending !== 1'b0) begin
      errors++;
      $display("FAIL async_reset data=%h en=%b fs=%b pend=%b want data=F en=1111 fs=0 pend=0",
               o_digit_data, o_digit_en, o_frame_start, o_pending);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    wait_fs();
    push_frame(16'h0000, 1'b0);
    for (int j = 0; j < 32; j++) begin
      exp_t x = sb.pop_front();
      checks++;
      if (o_digit_data !== x.d || o_digit_en !== x.e || o_frame_start !== (j == 0) || o_pending !== 1'b0) begin
        errors++;
        $display("FAIL post_reset j=%0d data=%h en=%b fs=%b pend=%b want data=%h en=%b fs=%b pend=0",
                 j, o_digit_data, o_digit_en, o_frame_start, o_pending, x.d, x.e, j == 0);
      end
      @(negedge clk);
    end
  endtask
  initial begin
    test_reset();
    test_idle();
    test_load_midframe();
    test_blank();
    test_last_wins();
    test_wrap_load();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
